// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage, producer side of the IF->ID interface.
// Holds the PC, issues single-outstanding requests on the sram-like bus and
// presents (addr, inst, delayslot_flag) through a one-entry output register.
// Branch redirects follow MIPS delay-slot rules; flush (exception/ERET) wins.
// Build option INST_FETCH_SKID_EN: adds a skid buffer and HOLD state so a
// request may be issued while the output register is stalled.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_addr,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        id_valid,
  output logic [31:0] id_addr,
  output logic [31:0] id_inst,
  output logic        id_delayslot_flag
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1
`ifdef INST_FETCH_SKID_EN
    , S_HOLD = 2'd2
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        discard_q, discard_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        ds_next_q, ds_next_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_addr_q, id_addr_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_ds_q, id_ds_d;
`ifdef INST_FETCH_SKID_EN
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_addr_q, skid_addr_d;
`endif

  logic        accept;
  logic        consume;
  logic        take;
  logic        load;
  logic [31:0] load_addr;
  logic [31:0] load_inst;

  assign inst_addr         = pc_q;
  assign id_valid          = id_valid_q;
  assign id_addr           = id_addr_q;
  assign id_inst           = id_inst_q;
  assign id_delayslot_flag = id_ds_q;

  // Request strobe: REQ state only; held low throughout reset.
  always_comb begin
    inst_req = 1'b0;
    if (rst_n && state_q == S_REQ) begin
`ifdef INST_FETCH_SKID_EN
      inst_req = 1'b1;
`else
      inst_req = !(id_valid_q && stall);
`endif
    end
  end

  // Next-state: bus FSM, output register, branch redirect, then flush override.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    discard_d    = discard_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    ds_next_d    = ds_next_q;
    id_valid_d   = id_valid_q;
    id_addr_d    = id_addr_q;
    id_inst_d    = id_inst_q;
    id_ds_d      = id_ds_q;
`ifdef INST_FETCH_SKID_EN
    skid_inst_d  = skid_inst_q;
    skid_addr_d  = skid_addr_q;
`endif
    accept    = inst_req && inst_addr_ok;
    consume   = id_valid_q && !stall;
    take      = consume && branch_flag;
    load      = 1'b0;
    load_addr = req_addr_q;
    load_inst = inst_rdata;

    case (state_q)
      S_REQ: begin
        if (accept) begin
          state_d    = S_RESP;
          req_addr_d = pc_q;
          if (redir_pend_q) begin
            pc_d         = redir_pc_q;
            redir_pend_d = 1'b0;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      S_RESP: begin
        if (inst_data_ok) begin
          state_d = S_REQ;
          if (discard_q) begin
            discard_d = 1'b0;
          end else if (!id_valid_q || !stall) begin
            load = 1'b1;
          end else begin
`ifdef INST_FETCH_SKID_EN
            skid_inst_d = inst_rdata;
            skid_addr_d = req_addr_q;
            state_d     = S_HOLD;
`else
            load = 1'b1;
`endif
          end
        end
      end
`ifdef INST_FETCH_SKID_EN
      S_HOLD: begin
        if (!stall) begin
          load      = 1'b1;
          load_addr = skid_addr_q;
          load_inst = skid_inst_q;
          state_d   = S_REQ;
        end
      end
`endif
      default: state_d = S_REQ;
    endcase

    // A load on the branch's own consume cycle is already the delay slot.
    if (load) begin
      id_valid_d = 1'b1;
      id_addr_d  = load_addr;
      id_inst_d  = load_inst;
      id_ds_d    = ds_next_q | take;
      ds_next_d  = 1'b0;
    end else begin
      ds_next_d = ds_next_q | take;
      if (consume) begin
        id_valid_d = 1'b0;
        id_inst_d  = '0;
        id_ds_d    = 1'b0;
      end
    end

    // Delay slot not yet issued: defer the redirect until it is accepted.
    if (take) begin
      if (pc_q == id_addr_q + 32'd4 && !accept) begin
        redir_pend_d = 1'b1;
        redir_pc_d   = branch_addr;
      end else begin
        pc_d = branch_addr;
      end
    end

    if (flush) begin
      pc_d         = flush_pc;
      id_valid_d   = 1'b0;
      id_inst_d    = '0;
      id_ds_d      = 1'b0;
      redir_pend_d = 1'b0;
      ds_next_d    = 1'b0;
      discard_d    = 1'b0;
      state_d      = S_REQ;
`ifdef INST_FETCH_SKID_EN
      skid_inst_d  = '0;
      skid_addr_d  = '0;
`endif
      if (state_q == S_RESP && !inst_data_ok) begin
        state_d   = S_RESP;
        discard_d = 1'b1;
      end else if (state_q == S_REQ && accept) begin
        state_d   = S_RESP;
        discard_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_addr_q   <= '0;
      discard_q    <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= '0;
      ds_next_q    <= 1'b0;
      id_valid_q   <= 1'b0;
      id_addr_q    <= '0;
      id_inst_q    <= '0;
      id_ds_q      <= 1'b0;
`ifdef INST_FETCH_SKID_EN
      skid_inst_q  <= '0;
      skid_addr_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      discard_q    <= discard_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      ds_next_q    <= ds_next_d;
      id_valid_q   <= id_valid_d;
      id_addr_q    <= id_addr_d;
      id_inst_q    <= id_inst_d;
      id_ds_q      <= id_ds_d;
`ifdef INST_FETCH_SKID_EN
      skid_inst_q  <= skid_inst_d;
      skid_addr_q  <= skid_addr_d;
`endif
    end
  end

endmodule
